// File: rtl/rs_encode_pkg.sv
// rs_encode_pkg: RS block geometry and the output-stage state enum shared with debug tooling.
package rs_encode_pkg;
  localparam int RS_DATA_BYTES    = 128;
  localparam int RS_PARITY_BYTES  = 32;
  localparam int LINE_BYTES       = 256 / 8;
  localparam int NUM_DATA_LINES   = RS_DATA_BYTES / LINE_BYTES;
  localparam int NUM_PARITY_LINES = (RS_PARITY_BYTES + LINE_BYTES - 1) / LINE_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;
endpackage

// File: rtl/rs_encode_stream_out_ctrl.sv
// rs_encode_stream_out_ctrl: request FSM and handshake steering for the output stage.
module rs_encode_stream_out_ctrl
  import rs_encode_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic meta_val_i,
  input  logic hdr_rdy_i,
  input  logic enc_val_i,
  input  logic dst_rdy_i,
  input  logic zero_blocks_i,
  input  logic last_i,
  output logic meta_rdy_o,
  output logic hdr_val_o,
  output logic enc_rdy_o,
  output logic dst_val_o,
  output logic store_meta_o,
  output logic init_counts_o,
  output logic incr_line_o,
  output logic busy_o
);
  state_e state_q, state_d;

  assign meta_rdy_o    = state_q == IDLE;
  assign hdr_val_o     = state_q == HDR;
  assign enc_rdy_o     = (state_q == DATA) & dst_rdy_i;
  assign dst_val_o     = (state_q == DATA) & enc_val_i;
  assign store_meta_o  = meta_rdy_o & meta_val_i;
  assign init_counts_o = store_meta_o;
  assign incr_line_o   = dst_val_o & dst_rdy_i;
  assign busy_o        = state_q != IDLE;

  always_comb begin
    state_d = store_meta_o                   ? HDR :
              (hdr_val_o & hdr_rdy_i)        ? (zero_blocks_i ? IDLE : DATA) :
              (incr_line_o & last_i)         ? IDLE :
                                               state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
endmodule

// File: rtl/rs_encode_stream_out_datap.sv
// rs_encode_stream_out_datap: block-count register, line/block counters and parity/last flags.
module rs_encode_stream_out_datap #(
  parameter int NUM_REQ_BLOCKS_W = 8,
  parameter int NUM_DATA_LINES   = 4,
  parameter int NUM_PARITY_LINES = 1,
  parameter int LINE_CNT_W       = $clog2(NUM_DATA_LINES + NUM_PARITY_LINES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        store_meta_i,
  input  logic                        init_counts_i,
  input  logic                        incr_line_i,
  input  logic [NUM_REQ_BLOCKS_W-1:0] num_blocks_i,
  output logic [NUM_REQ_BLOCKS_W-1:0] num_blocks_o,
  output logic                        zero_blocks_o,
  output logic                        parity_o,
  output logic                        last_o
);
  localparam logic [LINE_CNT_W-1:0]     LINE_MAX    = LINE_CNT_W'(NUM_DATA_LINES + NUM_PARITY_LINES - 1);
  localparam logic [LINE_CNT_W-1:0]     FIRST_PAR   = LINE_CNT_W'(NUM_DATA_LINES);
  localparam logic [NUM_REQ_BLOCKS_W:0] BLK_ONE     = (NUM_REQ_BLOCKS_W+1)'(1);

  logic [NUM_REQ_BLOCKS_W-1:0] num_blocks_q, num_blocks_d;
  logic [LINE_CNT_W-1:0]       line_cnt_q, line_cnt_d;
  logic [NUM_REQ_BLOCKS_W:0]   block_cnt_q, block_cnt_d;
  logic                        line_wrap;

  assign line_wrap     = line_cnt_q == LINE_MAX;
  assign num_blocks_o  = num_blocks_q;
  assign zero_blocks_o = num_blocks_q == '0;
  assign parity_o      = line_cnt_q >= FIRST_PAR;
  // Extra MSB keeps num_blocks-1 from underflowing into a false match.
  assign last_o        = line_wrap & (block_cnt_q == ({1'b0, num_blocks_q} - BLK_ONE));

  always_comb begin
    num_blocks_d = store_meta_i ? num_blocks_i : num_blocks_q;
    line_cnt_d   = init_counts_i ? '0 : incr_line_i ? (line_wrap ? '0 : line_cnt_q + 1'b1) : line_cnt_q;
    block_cnt_d  = init_counts_i ? '0 : (incr_line_i & line_wrap) ? block_cnt_q + BLK_ONE : block_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_blocks_q <= '0;
      line_cnt_q   <= '0;
      block_cnt_q  <= '0;
    end else begin
      num_blocks_q <= num_blocks_d;
      line_cnt_q   <= line_cnt_d;
      block_cnt_q  <= block_cnt_d;
    end
  end
endmodule

// File: rtl/rs_encode_stream_out.sv
// rs_encode_stream_out: emits a block-count header, then forwards encoded data/parity lines
// with parity and last markers.
module rs_encode_stream_out
  import rs_encode_pkg::*;
#(
  parameter int NUM_REQ_BLOCKS_W = 8,
  parameter int DATA_W           = 256,
  parameter int NUM_DATA_LINES   = rs_encode_pkg::NUM_DATA_LINES,
  parameter int NUM_PARITY_LINES = rs_encode_pkg::NUM_PARITY_LINES,
  parameter int LINE_CNT_W       = $clog2(NUM_DATA_LINES + NUM_PARITY_LINES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_datap_out_datap_meta_val,
  input  logic [NUM_REQ_BLOCKS_W-1:0] in_datap_out_datap_req_num_blocks,
  output logic                        out_datap_in_datap_meta_rdy,
  input  logic                        encoder_out_datap_val,
  input  logic [DATA_W-1:0]           encoder_out_datap_data,
  output logic                        out_datap_encoder_rdy,
  output logic                        out_datap_dst_hdr_val,
  output logic [NUM_REQ_BLOCKS_W-1:0] out_datap_dst_hdr_num_blocks,
  input  logic                        dst_out_datap_hdr_rdy,
  output logic                        out_datap_dst_data_val,
  output logic [DATA_W-1:0]           out_datap_dst_data,
  output logic                        out_datap_dst_data_parity,
  output logic                        out_datap_dst_data_last,
  input  logic                        dst_out_datap_data_rdy,
  output logic                        out_datap_busy
);
  logic store_meta, init_counts, incr_line, zero_blocks;

  assign out_datap_dst_data = encoder_out_datap_data;

  rs_encode_stream_out_ctrl u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .meta_val_i    (in_datap_out_datap_meta_val),
    .hdr_rdy_i     (dst_out_datap_hdr_rdy),
    .enc_val_i     (encoder_out_datap_val),
    .dst_rdy_i     (dst_out_datap_data_rdy),
    .zero_blocks_i (zero_blocks),
    .last_i        (out_datap_dst_data_last),
    .meta_rdy_o    (out_datap_in_datap_meta_rdy),
    .hdr_val_o     (out_datap_dst_hdr_val),
    .enc_rdy_o     (out_datap_encoder_rdy),
    .dst_val_o     (out_datap_dst_data_val),
    .store_meta_o  (store_meta),
    .init_counts_o (init_counts),
    .incr_line_o   (incr_line),
    .busy_o        (out_datap_busy)
  );

  rs_encode_stream_out_datap #(
    .NUM_REQ_BLOCKS_W (NUM_REQ_BLOCKS_W),
    .NUM_DATA_LINES   (NUM_DATA_LINES),
    .NUM_PARITY_LINES (NUM_PARITY_LINES),
    .LINE_CNT_W       (LINE_CNT_W)
  ) u_datap (
    .clk           (clk),
    .rst_n         (rst_n),
    .store_meta_i  (store_meta),
    .init_counts_i (init_counts),
    .incr_line_i   (incr_line),
    .num_blocks_i  (in_datap_out_datap_req_num_blocks),
    .num_blocks_o  (out_datap_dst_hdr_num_blocks),
    .zero_blocks_o (zero_blocks),
    .parity_o      (out_datap_dst_data_parity),
    .last_o        (out_datap_dst_data_last)
  );
endmodule

// File: doc/rs_encode_stream_out.md
Name: rs_encode_stream_out

Overview:
- Output stage of the streaming RS encoder. Sits directly downstream of the input datapath and the RS encode core.
- Takes the per-request block count from the input datapath and emits one header beat carrying it.
- Then passes every encoded line (data lines followed by parity lines, per block) to the destination stream.
- Marks parity lines and asserts last on the final line of the final block.

Parameters:
NUM_REQ_BLOCKS_W, 8, width of request block count
DATA_W, 256, stream line width in bits
NUM_DATA_LINES, 4, data lines per RS block (rs_encode_pkg: RS_DATA_BYTES/(DATA_W/8))
NUM_PARITY_LINES, 1, parity lines per RS block (rs_encode_pkg: ceil(RS_PARITY_BYTES/(DATA_W/8)))
LINE_CNT_W, $clog2(NUM_DATA_LINES+NUM_PARITY_LINES), line counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
in_datap_out_datap_meta_val  in  1  request metadata valid
in_datap_out_datap_req_num_blocks  in  NUM_REQ_BLOCKS_W  blocks in request
out_datap_in_datap_meta_rdy  out  1  metadata accepted
encoder_out_datap_val  in  1  encoded line valid
encoder_out_datap_data  in  DATA_W  encoded line
out_datap_encoder_rdy  out  1  encoded line accepted
out_datap_dst_hdr_val  out  1  header valid
out_datap_dst_hdr_num_blocks  out  NUM_REQ_BLOCKS_W  header payload
dst_out_datap_hdr_rdy  in  1  header accepted
out_datap_dst_data_val  out  1  output line valid
out_datap_dst_data  out  DATA_W  output line
out_datap_dst_data_parity  out  1  current line is parity
out_datap_dst_data_last  out  1  final line of request
dst_out_datap_data_rdy  in  1  output line accepted
out_datap_busy  out  1  state != IDLE

Behaviour:
- Handshake: transfer occurs when val & rdy are both high in the same cycle. A val, once raised, holds with stable payload until the transfer.
- FSM states IDLE, HDR, DATA. Reset value: IDLE. All counters and the registered block count reset to 0.
- Reset values of outputs: meta_rdy=1 (IDLE). Every other output is 0.
- IDLE:
  - meta_rdy=1.
  - On meta transfer: register num_blocks, clear line_cnt and block_cnt, go to HDR.
- HDR:
  - hdr_val=1; hdr_num_blocks = registered value.
  - On hdr transfer: if num_blocks==0, go to IDLE (zero-block request sends a header only). Otherwise go to DATA.
- DATA: zero-latency combinational pass-through.
  - dst_data_val = encoder val; encoder rdy = dst_data_rdy; dst_data = encoder data.
- Data-beat counting, on each data transfer:
  - If line_cnt == NUM_DATA_LINES+NUM_PARITY_LINES-1: line_cnt wraps to 0 and block_cnt increments.
  - Otherwise line_cnt increments.
- parity = (line_cnt >= NUM_DATA_LINES).
- last = (line_cnt == NUM_DATA_LINES+NUM_PARITY_LINES-1) & (block_cnt == num_blocks_reg-1).
  - Compare in NUM_REQ_BLOCKS_W+1 bits so no underflow at 0; DATA is never entered with 0 anyway.
- On a transfer with last=1: go to IDLE. The new request's meta_rdy rises the following cycle (no back-to-back meta in the last-beat cycle).
- Outside DATA: encoder rdy=0 and dst_data_val=0. Encoded lines arriving early are back-pressured.
- Outside IDLE: meta_rdy=0.
- Max request: 2^NUM_REQ_BLOCKS_W-1 blocks. block_cnt is NUM_REQ_BLOCKS_W+1 bits and never wraps.
- Async reset mid-operation: state goes to IDLE, counters clear, all vals drop immediately. Any partially transferred request is abandoned; upstream is reset by the same signal.
- Output vals, parity and last are combinational from state/counters and input val. No registered output latency.

Decomposition:
- rs_encode_pkg holds RS_DATA_BYTES, RS_PARITY_BYTES and the derived line counts. The state enum (IDLE/HDR/DATA) goes in the package for shared debug tooling.
- One natural split: rs_encode_stream_out_ctrl (FSM, handshake steering) plus rs_encode_stream_out_datap (num_blocks register, line/block counters, parity/last compares). Control strobes in the datap are store_meta, init_counts and incr_line. Top level instantiates both.

Test Plan:
- Meta num_blocks=2, all rdy=1, encoder streams 10 lines -> 1 header (num_blocks=2) then 10 data beats. parity=1 on beats 5 and 10; last=1 only on beat 10; busy low the cycle after.
- num_blocks=0 -> header with 0, zero data beats, encoder rdy never asserts, back to IDLE after header transfer.
- num_blocks=1, dst_data_rdy toggles 1/0 each cycle, encoder val held -> 5 transfers only on rdy cycles. Payload and parity flags stable while stalled; last on 5th.
- Encoder val=1 while in HDR with hdr_rdy=0 for 3 cycles -> encoder rdy=0 throughout, no data beats before header transfer.
- num_blocks=255 -> 1275 data beats; block_cnt reaches 254 with no wrap; last only on beat 1275.
- rst_n pulsed low after beat 3 of num_blocks=1 -> all vals 0 asynchronously, meta_rdy=1 after release. A new request of num_blocks=1 completes normally with last on its 5th beat.
